// File: rtl/signed_num_pkg.sv
// Shared constants for the signed/unsigned magnitude comparator.
package signed_num_pkg;

  // Operand interpretation selectors for CMP_MODE.
  localparam int CMP_UNSIGNED = 0;
  localparam int CMP_SIGNED   = 1;

  // Default operand width.
  localparam int DEF_CMP_WIDTH = 4;

endpackage : signed_num_pkg

// File: rtl/signed_num_if.sv
// Operand/result bundle for the comparator: the driver owns a/b, the comparator owns res.
interface signed_num_if
  import signed_num_pkg::*;
#(
  parameter int WIDTH = DEF_CMP_WIDTH
);

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             res;

  modport master (output a, output b, input res);
  modport slave  (input a, input b, output res);

endinterface : signed_num_if

// File: rtl/signed_num_gt_cmp.sv
// Combinational strict greater-than compare, signed or unsigned by CMP_MODE.
module gt_cmp
  import signed_num_pkg::*;
#(
  parameter int WIDTH    = DEF_CMP_WIDTH,
  parameter int CMP_MODE = CMP_SIGNED
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             gt
);

  // Both operands are remapped identically so the final compare is always
  // unsigned-vs-unsigned; no mixed-signedness expression can arise.
  logic [WIDTH-1:0] a_ord;
  logic [WIDTH-1:0] b_ord;

  generate
    if (CMP_MODE == CMP_SIGNED) begin : g_signed
      // Inverting the sign bit maps two's-complement order onto unsigned
      // order: most negative becomes 0, most positive becomes all ones.
      assign a_ord = {~a[WIDTH-1], a[WIDTH-2:0]};
      assign b_ord = {~b[WIDTH-1], b[WIDTH-2:0]};
    end else begin : g_unsigned
      assign a_ord = a;
      assign b_ord = b;
    end
  endgenerate

  assign gt = (a_ord > b_ord);

endmodule : gt_cmp

// File: rtl/signed_num.sv
// Registered comparator: res <= (a > b) each clock, cleared by synchronous active-low reset.
module signed_num
  import signed_num_pkg::*;
#(
  parameter int WIDTH    = DEF_CMP_WIDTH,
  parameter int CMP_MODE = CMP_SIGNED
) (
  input  logic        clk,
  input  logic        reset,
  signed_num_if.slave bus
);

  logic gt_next;
  logic res_reg;

  gt_cmp #(
    .WIDTH    (WIDTH),
    .CMP_MODE (CMP_MODE)
  ) u_gt_cmp (
    .a  (bus.a),
    .b  (bus.b),
    .gt (gt_next)
  );

  // Result register; reset wins over the new comparison.
  always_ff @(posedge clk) begin
    if (!reset) begin
      res_reg <= 1'b0;
    end else begin
      res_reg <= gt_next;
    end
  end

  assign bus.res = res_reg;

endmodule : signed_num

// File: tb/tb_signed_num.sv
// Self-checking bench: one signed and one unsigned comparator fed identical operands.
module tb_signed_num;
  import signed_num_pkg::*;

  localparam int W = DEF_CMP_WIDTH;

  logic clk;
  logic reset;

  signed_num_if #(.WIDTH(W)) if_s ();
  signed_num_if #(.WIDTH(W)) if_u ();

  signed_num #(.WIDTH(W), .CMP_MODE(CMP_SIGNED)) dut_s (
    .clk   (clk),
    .reset (reset),
    .bus   (if_s.slave)
  );

  signed_num #(.WIDTH(W), .CMP_MODE(CMP_UNSIGNED)) dut_u (
    .clk   (clk),
    .reset (reset),
    .bus   (if_u.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    bit         mode;   // 1 = signed DUT, 0 = unsigned DUT
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic       exp;
  } vec_t;

  vec_t vecs[$];

  // Reference: turn operands into plain integers under the chosen reading.
  function automatic logic ref_gt(bit mode, logic [W-1:0] a, logic [W-1:0] b);
    int va;
    int vb;
    va = int'(a);
    vb = int'(b);
    if (mode) begin
      if (va >= (1 << (W - 1))) va = va - (1 << W);
      if (vb >= (1 << (W - 1))) vb = vb - (1 << W);
    end
    return (va > vb) ? 1'b1 : 1'b0;
  endfunction

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got res=%b expected res=%b (a=%h b=%h)", name, act, exp, if_s.a, if_s.b);
    end else begin
      $display("ok   %s: res=%b (a=%h b=%h)", name, act, if_s.a, if_s.b);
    end
  endtask

  // Drive both DUTs, let one edge sample, then settle just after the edge.
  task automatic apply(input logic [W-1:0] a, input logic [W-1:0] b);
    if_s.a = a;
    if_s.b = b;
    if_u.a = a;
    if_u.b = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    // Directed table vectors with hand-derived expectations.
    vecs.push_back('{1'b1, 4'h4, 4'h1, 1'b1});
    vecs.push_back('{1'b1, 4'h4, 4'hF, 1'b1});
    vecs.push_back('{1'b1, 4'h7, 4'h8, 1'b1});
    vecs.push_back('{1'b1, 4'h8, 4'h7, 1'b0});
    vecs.push_back('{1'b1, 4'h8, 4'h8, 1'b0});
    vecs.push_back('{1'b1, 4'hF, 4'hE, 1'b1});
    vecs.push_back('{1'b1, 4'h3, 4'h3, 1'b0});
    vecs.push_back('{1'b1, 4'hF, 4'h0, 1'b0});
    vecs.push_back('{1'b0, 4'h4, 4'hF, 1'b0});
    vecs.push_back('{1'b0, 4'h4, 4'h1, 1'b1});
    vecs.push_back('{1'b0, 4'h8, 4'h7, 1'b1});
    vecs.push_back('{1'b0, 4'hF, 4'hE, 1'b1});
    vecs.push_back('{1'b0, 4'h0, 4'hF, 1'b0});
    vecs.push_back('{1'b0, 4'h5, 4'h5, 1'b0});

    // Reset held for two edges with a > b on the inputs.
    reset = 1'b0;
    if_s.a = 4'h4; if_s.b = 4'h1;
    if_u.a = 4'h4; if_u.b = 4'h1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset_s", if_s.res, 1'b0);
    check("reset_u", if_u.res, 1'b0);

    // Release: first comparison appears one edge later.
    reset = 1'b1;
    apply(4'h4, 4'h1);
    check("release_s", if_s.res, 1'b1);
    check("release_u", if_u.res, 1'b1);

    // Table-driven directed vectors.
    foreach (vecs[i]) begin
      apply(vecs[i].a, vecs[i].b);
      check($sformatf("vec%0d_%s", i, vecs[i].mode ? "s" : "u"),
            vecs[i].mode ? if_s.res : if_u.res, vecs[i].exp);
    end

    // Mid-operation reset.
    apply(4'h5, 4'h2);
    check("mid_pre_s", if_s.res, 1'b1);
    reset = 1'b0;
    apply(4'h5, 4'h2);
    check("mid_rst_s", if_s.res, 1'b0);
    check("mid_rst_u", if_u.res, 1'b0);
    reset = 1'b1;
    apply(4'h5, 4'h2);
    check("mid_post_s", if_s.res, 1'b1);

    // Inputs changing between edges must not disturb res.
    apply(4'h7, 4'h8);
    check("hold_a_s", if_s.res, 1'b1);
    if_s.a = 4'h8; if_s.b = 4'h7;
    if_u.a = 4'h8; if_u.b = 4'h7;
    #2;
    check("hold_b_s", if_s.res, 1'b1);
    @(posedge clk);
    #1;
    check("hold_c_s", if_s.res, 1'b0);

    // Exhaustive sweep, both modes at once.
    for (int ia = 0; ia < (1 << W); ia++) begin
      for (int ib = 0; ib < (1 << W); ib++) begin
        ra = ia[W-1:0];
        rb = ib[W-1:0];
        apply(ra, rb);
        check("sweep_s", if_s.res, ref_gt(1'b1, ra, rb));
        check("sweep_u", if_u.res, ref_gt(1'b0, ra, rb));
      end
    end

    // Random stimulus against the reference, with occasional reset pulses.
    for (int n = 0; n < 300; n++) begin
      ra = W'($urandom_range(0, (1 << W) - 1));
      rb = W'($urandom_range(0, (1 << W) - 1));
      reset = ($urandom_range(0, 19) == 0) ? 1'b0 : 1'b1;
      apply(ra, rb);
      check("rand_s", if_s.res, reset ? ref_gt(1'b1, ra, rb) : 1'b0);
      check("rand_u", if_u.res, reset ? ref_gt(1'b0, ra, rb) : 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_signed_num
